stall_scheduler: RTL and testbench

STALL_SCHEDULER -- requirements
Module: stall_scheduler

---
 rtl/stall_scheduler.sv | 123 ++++++++++++
 tb/tb_stall_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stall_scheduler.sv
// stall_scheduler
//   Hazard detection and multiply/divide unit (MDU) occupancy tracking for a
//   five-stage pipeline. A stall freezes PC and D and turns E into a bubble.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | MDU free, waiting for an issue in E
//   MULT  | multiply in progress, md_cnt cycles remaining
//   DIV   | divide in progress, md_cnt cycles remaining
//
// Ports
//   clk, reset                    single clock, synchronous active-high reset
//   D_rs, D_rt, D_*_tuse          sources of the D instruction and when it needs them
//   E_wa/M_wa, E_tnew/M_tnew      destinations in E/M and when their results are ready
//   D_md                          D instruction touches the MDU
//   E_md_start, E_md_div          MDU issue in E this cycle (1 = divide)
//   stall, PC_en, D_en, E_clr     combinational pipeline controls
//   md_busy, md_cnt               registered MDU occupancy
//   stall_cycles                  registered saturating count of stalled cycles
module stall_scheduler #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_rs_tuse,
    input  logic [1:0]  D_rt_tuse,
    input  logic [4:0]  E_wa,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  E_tnew,
    input  logic [1:0]  M_tnew,
    input  logic        D_md,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        stall,
    output logic        PC_en,
    output logic        D_en,
    output logic        E_clr,
    output logic        md_busy,
    output logic [3:0]  md_cnt,
    output logic [15:0] stall_cycles
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_LAT);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t state;

    logic rs_hz;
    logic rt_hz;
    logic md_hz;

    // A tuse of 3 can never be exceeded by a 2-bit tnew, so unused sources
    // drop out of the compare without a separate qualifier.
    assign rs_hz = (D_rs != 5'd0) &&
                   (((D_rs == E_wa) && (E_tnew > D_rs_tuse)) ||
                    ((D_rs == M_wa) && (M_tnew > D_rs_tuse)));

    assign rt_hz = (D_rt != 5'd0) &&
                   (((D_rt == E_wa) && (E_tnew > D_rt_tuse)) ||
                    ((D_rt == M_wa) && (M_tnew > D_rt_tuse)));

    // An issue in E this cycle counts as busy for the D instruction so the
    // MDU is never seen free one cycle early.
    assign md_hz = D_md && (md_busy || E_md_start);

    assign stall = rs_hz || rt_hz || md_hz;
    assign PC_en = !stall;
    assign D_en  = !stall;
    assign E_clr = stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            md_cnt       <= 4'd0;
            md_busy      <= 1'b0;
            stall_cycles <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (E_md_start) begin
                        md_busy <= 1'b1;
                        if (E_md_div) begin
                            state  <= DIV;
                            md_cnt <= DIV_LOAD;
                        end else begin
                            state  <= MULT;
                            md_cnt <= MULT_LOAD;
                        end
                    end
                end
                // A new issue while busy is ignored; the running count wins.
                MULT, DIV: begin
                    if (md_cnt == 4'd1) begin
                        state   <= IDLE;
                        md_cnt  <= 4'd0;
                        md_busy <= 1'b0;
                    end else begin
                        md_cnt <= md_cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    md_cnt  <= 4'd0;
                    md_busy <= 1'b0;
                end
            endcase

            if (stall && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_stall_scheduler.sv
// tb_stall_scheduler
//   Self-checking bench for stall_scheduler. Expected values are pushed to a
//   scoreboard queue as stimulus is applied and popped when the DUT output is
//   sampled, one cycle slot at a time.
module tb_stall_scheduler;

    logic        clk;
    logic        reset;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [1:0]  D_rs_tuse;
    logic [1:0]  D_rt_tuse;
    logic [4:0]  E_wa;
    logic [4:0]  M_wa;
    logic [1:0]  E_tnew;
    logic [1:0]  M_tnew;
    logic        D_md;
    logic        E_md_start;
    logic        E_md_div;
    logic        stall;
    logic        PC_en;
    logic        D_en;
    logic        E_clr;
    logic        md_busy;
    logic [3:0]  md_cnt;
    logic [15:0] stall_cycles;

    stall_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .D_rs         (D_rs),
        .D_rt         (D_rt),
        .D_rs_tuse    (D_rs_tuse),
        .D_rt_tuse    (D_rt_tuse),
        .E_wa         (E_wa),
        .M_wa         (M_wa),
        .E_tnew       (E_tnew),
        .M_tnew       (M_tnew),
        .D_md         (D_md),
        .E_md_start   (E_md_start),
        .E_md_div     (E_md_div),
        .stall        (stall),
        .PC_en        (PC_en),
        .D_en         (D_en),
        .E_clr        (E_clr),
        .md_busy      (md_busy),
        .md_cnt       (md_cnt),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_sc   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sb_push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input int got);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    task automatic idle_inputs();
        D_rs       = 5'd0;
        D_rt       = 5'd0;
        D_rs_tuse  = 2'd3;
        D_rt_tuse  = 2'd3;
        E_wa       = 5'd0;
        M_wa       = 5'd0;
        E_tnew     = 2'd0;
        M_tnew     = 2'd0;
        D_md       = 1'b0;
        E_md_start = 1'b0;
        E_md_div   = 1'b0;
    endtask

    task automatic comb_check(input bit st);
        sb_push("stall", int'(st));
        sb_push("pc_en", int'(!st));
        sb_push("d_en",  int'(!st));
        sb_push("e_clr", int'(st));
        #1;
        sb_pop(int'(stall));
        sb_pop(int'(PC_en));
        sb_pop(int'(D_en));
        sb_pop(int'(E_clr));
    endtask

    // Check the current-cycle controls, advance one clock, then check the
    // stall counter against the bench's own saturating count.
    task automatic step(input bit st);
        comb_check(st);
        @(posedge clk);
        if (reset)
            exp_sc = 0;
        else if (st && exp_sc != 65535)
            exp_sc++;
        #1;
        sb_push("stall_cycles", exp_sc);
        sb_pop(int'(stall_cycles));
    endtask

    task automatic md_check(input bit busy, input int cnt);
        sb_push("md_busy", int'(busy));
        sb_push("md_cnt", cnt);
        sb_pop(int'(md_busy));
        sb_pop(int'(md_cnt));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_sc = 0;
        md_check(0, 0);
        step(0);
        reset = 1'b0;
        step(0);
        md_check(0, 0);

        // load-use from E
        D_rs = 5'd8; D_rs_tuse = 2'd0; E_wa = 5'd8; E_tnew = 2'd2;
        step(1);
        D_rs = 5'd0;
        step(0);
        // E result ready exactly when needed
        D_rs = 5'd8; D_rs_tuse = 2'd2;
        step(0);
        idle_inputs();
        // M-stage forwardable vs. not
        D_rt = 5'd5; D_rt_tuse = 2'd1; M_wa = 5'd5; M_tnew = 2'd1;
        step(0);
        M_tnew = 2'd2;
        step(1);
        idle_inputs();
        // source marked unused
        D_rt = 5'd3; D_rt_tuse = 2'd3; E_wa = 5'd3; E_tnew = 2'd2;
        step(0);
        idle_inputs();
        // rs against M
        D_rs = 5'd7; D_rs_tuse = 2'd0; M_wa = 5'd7; M_tnew = 2'd1;
        step(1);
        idle_inputs();
        step(0);

        // multiply with D_md held through the busy window
        E_md_start = 1'b1; E_md_div = 1'b0; D_md = 1'b1;
        step(1);
        E_md_start = 1'b0;
        for (int c = 5; c >= 1; c--) begin
            md_check(1, c);
            step(1);
        end
        md_check(0, 0);
        comb_check(0);
        idle_inputs();
        step(0);

        // issue and hazard together: both take effect
        E_md_start = 1'b1; E_md_div = 1'b0;
        D_rs = 5'd9; D_rs_tuse = 2'd0; E_wa = 5'd9; E_tnew = 2'd1;
        step(1);
        idle_inputs();
        for (int c = 5; c >= 1; c--) begin
            md_check(1, c);
            step(0);
        end
        md_check(0, 0);

        // divide interrupted by reset at md_cnt = 6
        E_md_start = 1'b1; E_md_div = 1'b1;
        step(0);
        idle_inputs();
        for (int c = 10; c >= 7; c--) begin
            md_check(1, c);
            step(0);
        end
        md_check(1, 6);
        reset = 1'b1;
        D_md  = 1'b1;
        E_md_start = 1'b1;
        step(1);
        reset = 1'b0;
        idle_inputs();
        md_check(0, 0);
        step(0);
        md_check(0, 0);
        step(0);
        md_check(0, 0);

        // issue during DIV is ignored
        E_md_start = 1'b1; E_md_div = 1'b1;
        step(0);
        idle_inputs();
        for (int c = 10; c >= 8; c--) begin
            md_check(1, c);
            step(0);
        end
        md_check(1, 7);
        E_md_start = 1'b1; E_md_div = 1'b0;
        step(0);
        idle_inputs();
        for (int c = 6; c >= 1; c--) begin
            md_check(1, c);
            step(0);
        end
        md_check(0, 0);

        // saturation of the stall counter
        reset = 1'b1;
        step(0);
        reset = 1'b0;
        D_rs = 5'd8; D_rs_tuse = 2'd0; E_wa = 5'd8; E_tnew = 2'd2;
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        check("stall_cycles_fffe", int'(stall_cycles), 65534);
        @(posedge clk);
        #1;
        check("stall_cycles_ffff", int'(stall_cycles), 65535);
        for (int i = 0; i < 4465; i++) @(posedge clk);
        #1;
        check("stall_cycles_sat", int'(stall_cycles), 65535);
        check("stall_held", int'(stall), 1);
        idle_inputs();

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
